// File: rtl/wishbone_arbiter.sv
// wishbone_arbiter: shares one Wishbone slave among NUM_M masters.
// Round-robin (RR_MODE=1) or fixed-priority (RR_MODE=0) arbitration. A grant
// is held for the whole bus cycle, so bursts stay locked to one owner.
// Optional build macro WB_ARB_TIMEOUT_EN adds a stalled-slave watchdog:
// after TIMEOUT unacknowledged strobe cycles the owner receives a one-cycle
// m_err_o pulse and the slave bus is parked (ABORT) until the owner drops cyc.
module wishbone_arbiter #(
  parameter int NUM_M   = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_M-1:0]          m_cyc_i,
  input  logic [NUM_M-1:0]          m_stb_i,
  input  logic [NUM_M-1:0]          m_we_i,
  input  logic [NUM_M*AW-1:0]       m_addr_i,
  input  logic [NUM_M*DW-1:0]       m_data_i,
  input  logic [NUM_M*(DW/8)-1:0]   m_sel_i,
  output logic [DW-1:0]             m_data_o,
  output logic [NUM_M-1:0]          m_ack_o,
  output logic [NUM_M-1:0]          m_err_o,
  output logic [NUM_M-1:0]          grant_o,
  output logic [AW-1:0]             s_addr_o,
  output logic [DW-1:0]             s_data_o,
  output logic [DW/8-1:0]           s_sel_o,
  output logic                      s_we_o,
  output logic                      s_stb_o,
  output logic                      s_cyc_o,
  input  logic [DW-1:0]             s_data_i,
  input  logic                      s_ack_i
);

  localparam int SW = DW / 8;
  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  // Reject configurations the arbiter was not built for.
  if (NUM_M < 2 || NUM_M > 8) begin : g_bad_num_m
    $error("wishbone_arbiter: NUM_M must be in 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("wishbone_arbiter: TIMEOUT must be at least 1");
  end

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ABORT = 2'd2} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]    cnt_r;
  logic [NUM_M-1:0] err_r;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;
`endif

  state_t           state_r;
  logic [NUM_M-1:0] grant_r;
  logic [IW-1:0]    gidx_r;
  logic [IW-1:0]    ptr_r;
  logic [IW-1:0]    win_s;

  // Pointer value after releasing master g: the next index, wrapping to 0.
  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
    next_ptr = (int'(g) == NUM_M - 1) ? {IW{1'b0}} : g + 1'b1;
  endfunction

  // Pick the winner: scanning downward and overwriting leaves the first
  // requester in search order (from the pointer in RR mode, from 0 otherwise).
  always_comb begin
    int idx;
    win_s = {IW{1'b0}};
    idx   = 0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (RR_MODE != 0) begin
        idx = (int'(ptr_r) + i) % NUM_M;
      end else begin
        idx = i;
      end
      win_s = m_cyc_i[IW'(idx)] ? IW'(idx) : win_s;
    end
  end

  // Arbitration FSM: grant register, owner index, pointer and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      grant_r <= {NUM_M{1'b0}};
      gidx_r  <= {IW{1'b0}};
      ptr_r   <= {IW{1'b0}};
`ifdef WB_ARB_TIMEOUT_EN
      cnt_r   <= {CW{1'b0}};
      err_r   <= {NUM_M{1'b0}};
`endif
    end else begin
`ifdef WB_ARB_TIMEOUT_EN
      err_r <= {NUM_M{1'b0}};
`endif
      case (state_r)
        IDLE: begin
          if (|m_cyc_i) begin
            state_r <= BUSY;
            grant_r <= {{(NUM_M-1){1'b0}}, 1'b1} << win_s;
            gidx_r  <= win_s;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_r   <= {CW{1'b0}};
`endif
          end
        end
        BUSY: begin
          if (!m_cyc_i[gidx_r]) begin
            state_r <= IDLE;
            grant_r <= {NUM_M{1'b0}};
            ptr_r   <= next_ptr(gidx_r);
          end
`ifdef WB_ARB_TIMEOUT_EN
          else if (s_ack_i) begin
            cnt_r <= {CW{1'b0}};
          end else if (s_stb_o) begin
            if (cnt_r == CW'(TIMEOUT - 1)) begin
              err_r   <= grant_r;
              state_r <= ABORT;
              cnt_r   <= {CW{1'b0}};
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
          end
`endif
        end
`ifdef WB_ARB_TIMEOUT_EN
        ABORT: begin
          if (!m_cyc_i[gidx_r]) begin
            state_r <= IDLE;
            grant_r <= {NUM_M{1'b0}};
            ptr_r   <= next_ptr(gidx_r);
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          grant_r <= {NUM_M{1'b0}};
        end
      endcase
    end
  end

  // Connect the owner to the slave while BUSY; the bus is parked otherwise.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = {AW{1'b0}};
    s_data_o = {DW{1'b0}};
    s_sel_o  = {SW{1'b0}};
    m_ack_o  = {NUM_M{1'b0}};
    if (state_r == BUSY) begin
      s_cyc_o  = m_cyc_i[gidx_r];
      s_stb_o  = m_stb_i[gidx_r];
      s_we_o   = m_we_i[gidx_r];
      s_addr_o = m_addr_i[int'(gidx_r)*AW +: AW];
      s_data_o = m_data_i[int'(gidx_r)*DW +: DW];
      s_sel_o  = m_sel_i[int'(gidx_r)*SW +: SW];
      // An ack without an active strobe belongs to no transfer.
      m_ack_o[gidx_r] = s_ack_i & m_stb_i[gidx_r];
    end else begin
      m_ack_o = {NUM_M{1'b0}};
    end
  end

  assign m_data_o = s_data_i;
  assign grant_o  = grant_r;
`ifdef WB_ARB_TIMEOUT_EN
  assign m_err_o  = err_r;
`else
  assign m_err_o  = {NUM_M{1'b0}};
`endif

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Bench for wishbone_arbiter: a 4-master round-robin instance and a 2-master
// fixed-priority instance share one stimulus bus (the fixed one sees masters
// 0 and 1). Both are compared against an owner/pointer reference model.
module tb_wishbone_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [3:0] cyc, stb, we;
  logic [4*AW-1:0] addr;
  logic [4*DW-1:0] wdat;
  logic [15:0] sel;
  logic [DW-1:0] sdat;
  logic ack;

  logic [DW-1:0] r_mdat, r_sdat, f_mdat, f_sdat;
  logic [3:0] r_ack, r_err, r_gnt, r_sel, f_sel;
  logic [1:0] f_ack, f_err, f_gnt;
  logic [AW-1:0] r_addr, f_addr;
  logic r_we, r_stb, r_cyc, f_we, f_stb, f_cyc;
  logic [70:0] r_bus, f_bus;

  int errors = 0;
  int checks = 0;

  // Reference model: current owner (-1 = none), pointer, stall count.
  int owner[2], ptr[2], cnt[2];
  bit abrt[2], errp[2];

  wishbone_arbiter #(.NUM_M(4), .AW(AW), .DW(DW), .RR_MODE(1), .TIMEOUT(TO)) u_rr (
    .clk(clk), .rst(rst),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
    .m_addr_i(addr), .m_data_i(wdat), .m_sel_i(sel),
    .m_data_o(r_mdat), .m_ack_o(r_ack), .m_err_o(r_err), .grant_o(r_gnt),
    .s_addr_o(r_addr), .s_data_o(r_sdat), .s_sel_o(r_sel), .s_we_o(r_we),
    .s_stb_o(r_stb), .s_cyc_o(r_cyc), .s_data_i(sdat), .s_ack_i(ack));

  wishbone_arbiter #(.NUM_M(2), .AW(AW), .DW(DW), .RR_MODE(0), .TIMEOUT(TO)) u_fx (
    .clk(clk), .rst(rst),
    .m_cyc_i(cyc[1:0]), .m_stb_i(stb[1:0]), .m_we_i(we[1:0]),
    .m_addr_i(addr[2*AW-1:0]), .m_data_i(wdat[2*DW-1:0]), .m_sel_i(sel[7:0]),
    .m_data_o(f_mdat), .m_ack_o(f_ack), .m_err_o(f_err), .grant_o(f_gnt),
    .s_addr_o(f_addr), .s_data_o(f_sdat), .s_sel_o(f_sel), .s_we_o(f_we),
    .s_stb_o(f_stb), .s_cyc_o(f_cyc), .s_data_i(sdat), .s_ack_i(ack));

  assign r_bus = {r_cyc, r_stb, r_we, r_addr, r_sdat, r_sel};
  assign f_bus = {f_cyc, f_stb, f_we, f_addr, f_sdat, f_sel};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic int nm(int d);
    return (d == 0) ? 4 : 2;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      owner[d] = -1; ptr[d] = 0; cnt[d] = 0; abrt[d] = 1'b0; errp[d] = 1'b0;
    end
  endtask

  // One clock of the arbitration rules, applied to the inputs at the edge.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int n, pick, base;
      n = nm(d);
      errp[d] = 1'b0;
      if (owner[d] < 0) begin
        pick = -1;
        base = (d == 0) ? ptr[d] : 0;
        for (int k = 0; k < n; k++)
          if (pick < 0 && cyc[(base + k) % n]) pick = (base + k) % n;
        if (pick >= 0) begin
          owner[d] = pick; cnt[d] = 0; abrt[d] = 1'b0;
        end
      end else if (!cyc[owner[d]]) begin
        ptr[d] = (owner[d] + 1) % n;
        owner[d] = -1;
        abrt[d] = 1'b0;
      end else if (TO_EN && !abrt[d]) begin
        if (ack) cnt[d] = 0;
        else if (stb[owner[d]]) begin
          cnt[d]++;
          if (cnt[d] == TO) begin errp[d] = 1'b1; abrt[d] = 1'b1; end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    @(negedge clk);
  endtask

  function automatic logic [3:0] exp_gnt(int d);
    return (owner[d] < 0) ? 4'b0000 : 4'(1 << owner[d]);
  endfunction

  function automatic logic [70:0] exp_bus(int d);
    int o;
    o = owner[d];
    if (o < 0 || abrt[d]) return 71'd0;
    return {cyc[o], stb[o], we[o], addr[o*AW +: AW], wdat[o*DW +: DW], sel[o*4 +: 4]};
  endfunction

  function automatic logic [3:0] exp_ack(int d);
    int o;
    o = owner[d];
    if (o < 0 || abrt[d]) return 4'b0000;
    return (stb[o] && ack) ? 4'(1 << o) : 4'b0000;
  endfunction

  function automatic logic [3:0] exp_err(int d);
    return (errp[d] && owner[d] >= 0) ? 4'(1 << owner[d]) : 4'b0000;
  endfunction

  task automatic idle_inputs();
    cyc = 4'b0000; stb = 4'b0000; we = 4'b0000; ack = 1'b0;
    addr = {$urandom, $urandom, $urandom, $urandom};
    wdat = {$urandom, $urandom, $urandom, $urandom};
    sel = 16'($urandom); sdat = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    cyc = 4'b1111; stb = 4'b1111; ack = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    #1;
    checks++; if (r_gnt !== 4'b0000) begin errors++; $display("FAIL reset_rr_grant got=%b exp=0000", r_gnt); end
    checks++; if (r_bus !== 71'd0) begin errors++; $display("FAIL reset_rr_sbus got=%h exp=0", r_bus); end
    checks++; if ({r_ack, r_err} !== 8'h00) begin errors++; $display("FAIL reset_rr_ack_err got=%b exp=0", {r_ack, r_err}); end
    checks++; if ({f_gnt, f_ack, f_err} !== 6'b0) begin errors++; $display("FAIL reset_fx_outs got=%b exp=0", {f_gnt, f_ack, f_err}); end
    checks++; if (f_bus !== 71'd0) begin errors++; $display("FAIL reset_fx_sbus got=%h exp=0", f_bus); end
    checks++; if (r_mdat !== sdat) begin errors++; $display("FAIL reset_mdata got=%h exp=%h", r_mdat, sdat); end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_simultaneous();
    cyc = 4'b0011; stb = 4'b0011;
    #1;
    checks++; if (r_gnt !== 4'b0000) begin errors++; $display("FAIL sim_no_early_grant got=%b exp=0000", r_gnt); end
    tick();
    checks++; if (r_gnt !== 4'b0001) begin errors++; $display("FAIL sim_rr_first got=%b exp=0001", r_gnt); end
    checks++; if (f_gnt !== 2'b01) begin errors++; $display("FAIL sim_fx_first got=%b exp=01", f_gnt); end
    checks++; if (r_bus !== exp_bus(0)) begin errors++; $display("FAIL sim_rr_route got=%h exp=%h", r_bus, exp_bus(0)); end
    cyc = 4'b0010;
    tick();
    checks++; if (r_gnt !== 4'b0000) begin errors++; $display("FAIL sim_dead_cycle got=%b exp=0000", r_gnt); end
    checks++; if (r_cyc !== 1'b0) begin errors++; $display("FAIL sim_dead_scyc got=%b exp=0", r_cyc); end
    cyc = 4'b0011;
    tick();
    checks++; if (r_gnt !== 4'b0010) begin errors++; $display("FAIL sim_rr_second got=%b exp=0010", r_gnt); end
    checks++; if (f_gnt !== 2'b01) begin errors++; $display("FAIL sim_fx_second got=%b exp=01", f_gnt); end
    for (int i = 0; i < 3; i++) begin
      cyc = 4'b0010;
      tick();
      checks++; if (f_gnt !== 2'b00) begin errors++; $display("FAIL starve_fx_release it=%0d got=%b exp=00", i, f_gnt); end
      cyc = 4'b0011;
      tick();
      checks++; if (f_gnt !== 2'b01) begin errors++; $display("FAIL starve_fx_regrant it=%0d got=%b exp=01", i, f_gnt); end
      checks++; if (r_gnt !== 4'b0010) begin errors++; $display("FAIL starve_rr_lock it=%0d got=%b exp=0010", i, r_gnt); end
    end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_burst();
    cyc = 4'b0011; stb = 4'b0001; we = 4'b0000;
    tick();
    checks++; if (r_gnt !== 4'b0001) begin errors++; $display("FAIL burst_grant got=%b exp=0001", r_gnt); end
    for (int b = 0; b < 4; b++) begin
      sdat = 32'(17 * (b + 1)); ack = 1'b1;
      #1;
      checks++; if (r_ack !== 4'b0001) begin errors++; $display("FAIL burst_ack beat=%0d got=%b exp=0001", b, r_ack); end
      checks++; if (r_mdat !== 32'(17 * (b + 1))) begin errors++; $display("FAIL burst_data beat=%0d got=%h exp=%h", b, r_mdat, 32'(17 * (b + 1))); end
      checks++; if (f_ack !== 2'b01) begin errors++; $display("FAIL burst_fx_ack beat=%0d got=%b exp=01", b, f_ack); end
      tick();
      checks++; if (r_gnt !== 4'b0001) begin errors++; $display("FAIL burst_hold beat=%0d got=%b exp=0001", b, r_gnt); end
    end
    ack = 1'b0; cyc = 4'b0010;
    tick();
    checks++; if (r_gnt !== 4'b0000) begin errors++; $display("FAIL burst_release got=%b exp=0000", r_gnt); end
    idle_inputs();
    tick();
  endtask

  task automatic test_pointer();
    cyc = 4'b0010; stb = 4'b0010;
    tick();
    cyc = 4'b0000;
    tick();
    checks++; if (r_gnt !== 4'b0000) begin errors++; $display("FAIL ptr_release got=%b exp=0000", r_gnt); end
    cyc = 4'b1010; stb = 4'b1010;
    tick();
    checks++; if (r_gnt !== 4'b1000) begin errors++; $display("FAIL ptr2_wins3 got=%b exp=1000", r_gnt); end
    cyc = 4'b0000;
    tick();
    cyc = 4'b1010;
    tick();
    checks++; if (r_gnt !== 4'b0010) begin errors++; $display("FAIL ptr_wrap0 got=%b exp=0010", r_gnt); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_ack_without_stb();
    cyc = 4'b0001; stb = 4'b0000;
    tick();
    ack = 1'b1;
    #1;
    checks++; if ({r_ack, f_ack} !== 6'b0) begin errors++; $display("FAIL nostb_ack got=%b exp=0", {r_ack, f_ack}); end
    stb = 4'b0001;
    #1;
    checks++; if (r_ack !== 4'b0001) begin errors++; $display("FAIL stb_ack got=%b exp=0001", r_ack); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_timeout();
    int pulses, at;
    pulses = 0; at = -1;
    cyc = 4'b0001; stb = 4'b0001; ack = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      #1;
      if (r_err[0]) begin pulses++; at = i; end
      checks++; if (r_err !== exp_err(0)) begin errors++; $display("FAIL to_err cyc=%0d got=%b exp=%b", i, r_err, exp_err(0)); end
      checks++; if (r_bus !== exp_bus(0)) begin errors++; $display("FAIL to_sbus cyc=%0d got=%h exp=%h", i, r_bus, exp_bus(0)); end
      checks++; if (r_gnt !== 4'b0001) begin errors++; $display("FAIL to_grant_held cyc=%0d got=%b exp=0001", i, r_gnt); end
      tick();
    end
    checks++; if (pulses !== (TO_EN ? 1 : 0)) begin errors++; $display("FAIL to_pulses got=%0d exp=%0d", pulses, TO_EN ? 1 : 0); end
    checks++; if (at !== (TO_EN ? TO : -1)) begin errors++; $display("FAIL to_pulse_time got=%0d exp=%0d", at, TO_EN ? TO : -1); end
    cyc = 4'b0000;
    tick();
    checks++; if (r_gnt !== 4'b0000) begin errors++; $display("FAIL to_idle got=%b exp=0000", r_gnt); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    cyc = 4'b0001; stb = 4'b0001;
    tick();
    cyc = 4'b0000;
    tick();
    cyc = 4'b0100; stb = 4'b0100; ack = 1'b1;
    tick();
    checks++; if (r_stb !== 1'b1) begin errors++; $display("FAIL rmid_busy got=%b exp=1", r_stb); end
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++; if (r_gnt !== 4'b0000) begin errors++; $display("FAIL rmid_grant got=%b exp=0000", r_gnt); end
    checks++; if (r_bus !== 71'd0) begin errors++; $display("FAIL rmid_sbus got=%h exp=0", r_bus); end
    checks++; if ({r_ack, r_err} !== 8'h00) begin errors++; $display("FAIL rmid_ack_err got=%b exp=0", {r_ack, r_err}); end
    @(negedge clk);
    rst = 1'b0; ack = 1'b0;
    cyc = 4'b0101; stb = 4'b0101;
    #1;
    checks++; if (r_ack !== 4'b0000) begin errors++; $display("FAIL rmid_no_late_ack got=%b exp=0000", r_ack); end
    tick();
    checks++; if (r_gnt !== 4'b0001) begin errors++; $display("FAIL rmid_fresh_arb got=%b exp=0001", r_gnt); end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int m = 0; m < 4; m++) if ($urandom_range(7) == 0) cyc[m] = ~cyc[m];
      stb = 4'($urandom); we = 4'($urandom); sel = 16'($urandom);
      addr = {$urandom, $urandom, $urandom, $urandom};
      wdat = {$urandom, $urandom, $urandom, $urandom};
      sdat = $urandom; ack = ($urandom_range(3) == 0);
      #1;
      checks++; if (r_gnt !== exp_gnt(0)) begin errors++; $display("FAIL rnd_rr_grant c=%0d got=%b exp=%b", c, r_gnt, exp_gnt(0)); end
      checks++; if (r_bus !== exp_bus(0)) begin errors++; $display("FAIL rnd_rr_sbus c=%0d got=%h exp=%h", c, r_bus, exp_bus(0)); end
      checks++; if (r_ack !== exp_ack(0)) begin errors++; $display("FAIL rnd_rr_ack c=%0d got=%b exp=%b", c, r_ack, exp_ack(0)); end
      checks++; if (r_err !== exp_err(0)) begin errors++; $display("FAIL rnd_rr_err c=%0d got=%b exp=%b", c, r_err, exp_err(0)); end
      checks++; if (r_mdat !== sdat) begin errors++; $display("FAIL rnd_rr_mdata c=%0d got=%h exp=%h", c, r_mdat, sdat); end
      checks++; if ({2'b00, f_gnt} !== exp_gnt(1)) begin errors++; $display("FAIL rnd_fx_grant c=%0d got=%b exp=%b", c, f_gnt, exp_gnt(1)); end
      checks++; if (f_bus !== exp_bus(1)) begin errors++; $display("FAIL rnd_fx_sbus c=%0d got=%h exp=%h", c, f_bus, exp_bus(1)); end
      checks++; if ({2'b00, f_ack} !== exp_ack(1)) begin errors++; $display("FAIL rnd_fx_ack c=%0d got=%b exp=%b", c, f_ack, exp_ack(1)); end
      checks++; if ({2'b00, f_err} !== exp_err(1)) begin errors++; $display("FAIL rnd_fx_err c=%0d got=%b exp=%b", c, f_err, exp_err(1)); end
      checks++; if (f_mdat !== sdat) begin errors++; $display("FAIL rnd_fx_mdata c=%0d got=%h exp=%h", c, f_mdat, sdat); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_burst();
    test_pointer();
    test_ack_without_stb();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter.md
WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
REQ-001 SHALL have parameter NUM_M, default 2, number of wishbone masters (2..8).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width; select width SW = DW/8.
REQ-004 SHALL have parameter RR_MODE, default 1; 1 = round-robin, 0 = fixed priority (index 0 highest).
REQ-005 SHALL have parameter TIMEOUT, default 255, cycles without ack before abort (used only under REQ-027).
REQ-006 SHALL have ports clk in 1, single clock; rst in 1, asynchronous, active-high reset.
REQ-007 SHALL have ports m_cyc_i in NUM_M, m_stb_i in NUM_M, m_we_i in NUM_M: per-master controls.
REQ-008 SHALL have ports m_addr_i in NUM_M*AW, m_data_i in NUM_M*DW, m_sel_i in NUM_M*SW: flattened, master k at slice k.
REQ-009 SHALL have ports m_data_o out DW (shared read data), m_ack_o out NUM_M, m_err_o out NUM_M, grant_o out NUM_M (one-hot).
REQ-010 SHALL have ports s_addr_o out AW, s_data_o out DW, s_sel_o out SW, s_we_o out 1, s_stb_o out 1, s_cyc_o out 1, s_data_i in DW, s_ack_i in 1.

Function
REQ-011 SHALL implement states IDLE, BUSY (plus ABORT under REQ-027).
REQ-012 IDLE: when any m_cyc_i set, SHALL register winner into grant_o and enter BUSY next edge; grant latency exactly 1 cycle from cyc.
REQ-013 Fixed mode: winner = lowest index with m_cyc_i set.
REQ-014 Round-robin mode: winner = first requester at or after pointer, searching upward with wrap from NUM_M-1 to 0.
REQ-015 Pointer SHALL update to (granted index + 1) mod NUM_M when BUSY exits; unchanged otherwise.
REQ-016 BUSY: s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o SHALL combinationally equal granted master's slice.
REQ-017 BUSY: m_ack_o[g] = s_ack_i for granted g only; all other m_ack_o bits 0.
REQ-018 m_data_o SHALL equal s_data_i at all times.
REQ-019 Outside BUSY, all s_* outputs SHALL be 0, all m_ack_o 0.
REQ-020 BUSY SHALL hold grant while granted m_cyc_i stays 1 (multi-beat/burst lock); requests from others are ignored.
REQ-021 Granted m_cyc_i falling SHALL return to IDLE next edge, grant_o cleared; re-arbitration occurs in that IDLE cycle (1 dead cycle between owners).
REQ-022 Simultaneous requests in IDLE: exactly one grant per REQ-013/014; losers wait with no ack.
REQ-023 Master dropping m_cyc_i before grant SHALL not be granted.
REQ-024 Ack arriving when s_stb_o = 0 SHALL be ignored.

Reset
REQ-025 rst asserted SHALL asynchronously force state IDLE, grant_o 0, pointer 0, timeout counter 0, m_ack_o 0, m_err_o 0, all s_* outputs 0.
REQ-026 rst mid-transaction SHALL abandon it immediately; no ack or err generated for it after release.

Configuration
REQ-027 With WB_ARB_TIMEOUT_EN defined: counter SHALL clear on grant and every s_ack_i, increment each BUSY cycle with s_stb_o=1 and s_ack_i=0; on reaching TIMEOUT, m_err_o[g] SHALL pulse 1 cycle, state enters ABORT with s_* = 0, ABORT returns to IDLE after granted m_cyc_i falls, pointer updated per REQ-015.
REQ-028 Without WB_ARB_TIMEOUT_EN: no counter, no ABORT state, m_err_o tied 0; stalled slave holds grant indefinitely.

Verification
REQ-029 NUM_M=2, RR_MODE=1, both m_cyc_i rise same cycle, pointer 0 -> grant_o=2'b01 next cycle; after master 0 drops cyc and both re-request, grant_o=2'b10.
REQ-030 RR_MODE=0, master 1 requesting continuously, master 0 requests -> master 0 granted at every IDLE arbitration; master 1 starved.
REQ-031 Master 0 4-beat read, slave acks each beat with s_data_i 0x11,0x22,0x33,0x44 -> m_ack_o[0] 4 pulses, m_data_o matches, m_ack_o[1]=0 throughout, grant held.
REQ-032 NUM_M=4, masters 1 and 3 request, pointer 2 -> master 3 granted; pointer becomes 0 after release.
REQ-033 WB_ARB_TIMEOUT_EN, TIMEOUT=8, slave never acks -> m_err_o[g] pulses after 8 stalled cycles, s_cyc_o=0 next cycle, IDLE after m_cyc_i falls.
REQ-034 rst pulsed during BUSY with s_stb_o=1 -> all outputs 0 immediately, pointer 0, fresh arbitration after release.
